// File: rtl/grant_pkg.sv
// Shared types and helpers for consumers of the 4-way arbiter grant.
// Entry layout and one-hot decode live here so every consumer agrees.
package grant_pkg;

    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int ID_W   = 2;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic [ID_W-1:0] onehot_to_idx(
        input logic [N_REQ-1:0] oh
    );
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = idx | ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word fall-through read port.
// A push while full is taken only when a pop frees the head slot.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/grant_dispatch_fifo.sv
// Queues arbiter grants with their data and hands them to a shared
// resource over valid/ready, pulsing done back to the owner on consume.
module grant_dispatch_fifo
    import grant_pkg::*;
#(
    parameter int N     = N_REQ,
    parameter int DW    = DATA_W,
    parameter int DEPTH = 4,
    parameter int IDW   = ID_W,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    grant,
    input  logic [N*DW-1:0] req_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDW-1:0]  out_id,
    output logic [DW-1:0]   out_data,
    output logic [N-1:0]    done,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            overflow,
    output logic            onehot_err
);

    logic           any_bit;
    logic           multi;
    logic           single;
    logic [IDW-1:0] gidx;
    logic           pop;
    logic           push;
    logic           empty;
    entry_t         wr_entry;
    entry_t         rd_entry;
    entry_t         held;

    // x & (x-1) clears the lowest set bit; anything left means multi-hot
    assign any_bit = |grant;
    assign multi   = |(grant & (grant - N'(1)));
    assign single  = any_bit && !multi;
    assign gidx    = onehot_to_idx(grant);

    assign wr_entry.id   = gidx;
    assign wr_entry.data = req_data[gidx*DW +: DW];

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign push      = single;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (rd_entry),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Once drained, keep showing the last head instead of stale slots
    assign out_id   = empty ? held.id   : rd_entry.id;
    assign out_data = empty ? held.data : rd_entry.data;

    always_ff @(posedge clk) begin
        if (rst) begin
            held       <= '0;
            done       <= '0;
            overflow   <= 1'b0;
            onehot_err <= 1'b0;
        end else begin
            if (!empty) held <= rd_entry;
            done <= pop ? (N'(1) << rd_entry.id) : '0;
            if (single && full && !pop) overflow <= 1'b1;
            if (multi) onehot_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_grant_dispatch_fifo.sv
// Directed bench for grant_dispatch_fifo with a queue scoreboard
// and a negedge monitor that checks every pop and done pulse.
module tb_grant_dispatch_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  grant;
    logic [31:0] req_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [7:0]  out_data;
    logic [3:0]  done;
    logic [2:0]  count;
    logic        full;
    logic        overflow;
    logic        onehot_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t       q[$];
    logic [3:0] exp_done = 4'b0;

    always #5 clk = ~clk;

    grant_dispatch_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .grant      (grant),
        .req_data   (req_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_data   (out_data),
        .done       (done),
        .count      (count),
        .full       (full),
        .overflow   (overflow),
        .onehot_err (onehot_err)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: inputs are stable at negedge, so a pop seen here
    // happens at the next posedge and its done shows a cycle later.
    always @(negedge clk) begin
        if (rst) begin
            exp_done = 4'b0;
        end else begin
            exp_t e;
            chk("done", int'(done), int'(exp_done));
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            exp_done = 4'b0;
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("pop_id", int'(out_id), e.id);
                chk("pop_data", int'(out_data), e.data);
                exp_done = 4'b0001 << e.id;
            end
        end
    end

    // Drive one grant cycle; acc says whether the DUT should take it.
    task automatic gnt(input logic [3:0] g, input logic [7:0] d,
                       input int id, input bit acc);
        exp_t e;
        grant    = g;
        req_data = 32'hDEADBEEF;
        req_data[id*8 +: 8] = d;
        @(posedge clk);
        if (acc) begin
            e.id   = id;
            e.data = int'(d);
            q.push_back(e);
        end
        #1;
        grant = 4'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        grant     = 4'b0;
        req_data  = 32'h0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_oherr", int'(onehot_err), 0);
        chk("rst_id", int'(out_id), 0);
        chk("rst_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single grant, consumed immediately
        out_ready = 1'b1;
        gnt(4'b0100, 8'hA5, 2, 1);
        idle(3);
        @(negedge clk);
        chk("single_count", int'(count), 0);
        idle(1);

        // burst while stalled fills the FIFO
        out_ready = 1'b0;
        gnt(4'b0001, 8'h11, 0, 1);
        gnt(4'b0010, 8'h22, 1, 1);
        gnt(4'b0100, 8'h33, 2, 1);
        gnt(4'b1000, 8'h44, 3, 1);
        @(negedge clk);
        chk("burst_count", int'(count), 4);
        chk("burst_full", int'(full), 1);
        idle(1);

        // dropped grant while full
        gnt(4'b0010, 8'h55, 1, 0);
        @(negedge clk);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 4);
        idle(1);

        // full plus pop accepts the grant
        out_ready = 1'b1;
        gnt(4'b0001, 8'h66, 0, 1);
        @(negedge clk);
        chk("fullpop_count", int'(count), 4);
        chk("ovf_sticky", int'(overflow), 1);
        idle(6);
        @(negedge clk);
        chk("drain_count", int'(count), 0);
        idle(1);

        // multi-hot grant is rejected
        gnt(4'b0110, 8'h77, 1, 0);
        @(negedge clk);
        chk("oh_err", int'(onehot_err), 1);
        chk("oh_count", int'(count), 0);
        idle(1);
        out_ready = 1'b0;
        gnt(4'b0001, 8'h88, 0, 1);
        @(negedge clk);
        chk("after_oh_count", int'(count), 1);
        idle(1);

        // simultaneous push and pop
        out_ready = 1'b1;
        gnt(4'b1000, 8'h99, 3, 1);
        @(negedge clk);
        chk("pp_count", int'(count), 1);
        chk("pp_head", int'(out_id), 3);
        idle(3);
        out_ready = 1'b0;

        // reset mid-operation discards queued entries
        gnt(4'b0001, 8'hA1, 0, 1);
        gnt(4'b0010, 8'hB2, 1, 1);
        gnt(4'b1000, 8'hC3, 3, 1);
        @(negedge clk);
        chk("pre_rst_count", int'(count), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        chk("mid_rst_oherr", int'(onehot_err), 0);
        idle(1);
        out_ready = 1'b1;
        gnt(4'b0100, 8'h5C, 2, 1);
        idle(4);
        @(negedge clk);
        chk("final_count", int'(count), 0);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/grant_dispatch_fifo.md
Name: grant_dispatch_fifo

Overview:
Downstream consumer of the 4-way fixed-order arbiter. Samples the arbiter's registered one-hot grant each cycle and captures the granted requester's index plus its data word into a small FIFO. Presents entries to the shared resource over a valid/ready interface, and returns a one-cycle done pulse to the originating requester when its entry is consumed. Absorbs back-to-back grants while the resource is stalled.

Parameters:
N, 4, number of requesters; equals the arbiter width.
DW, 8, data word width per requester.
DEPTH, 4, number of FIFO entries; power of 2, at least 2.
IDW, 2, index width; equals clog2(N).

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
grant  input  N  one-hot grant from the arbiter; all zeros means idle.
req_data  input  N*DW  requester data; slice i is [i*DW +: DW].
out_valid  output  1  head entry is available.
out_ready  input  1  resource accepts the head entry.
out_id  output  IDW  requester index of the head entry.
out_data  output  DW  data of the head entry.
done  output  N  one-cycle one-hot pulse to the requester whose entry was consumed.
count  output  clog2(DEPTH+1)  current occupancy.
full  output  1  count == DEPTH.
overflow  output  1  sticky; a valid grant was dropped because the FIFO was full.
onehot_err  output  1  sticky; a multi-hot grant was seen.

Behaviour:
- Reset values: when rst is high at a clock edge, all outputs take these values.
  - count=0, out_valid=0, full=0.
  - done=0, overflow=0, onehot_err=0.
  - out_id=0, out_data=0.
  - Read and write pointers are cleared and stored entries are discarded.
- Reset mid-operation: any queued entries are lost, and no done pulse is issued for them.
- Grant classification, evaluated each cycle:
  - valid grant: exactly one bit set.
  - idle: zero bits set.
  - multi-hot: two or more bits set.
- Push: a valid grant is pushed on the same edge it is sampled.
  - The entry is {index of the set bit, req_data slice of that index}, with data sampled in the same cycle as the grant.
- Pop: occurs when out_valid && out_ready.
- Latency: a grant sampled at edge E gives out_valid=1 in the cycle after E if the FIFO was empty (1-cycle latency).
  - The FIFO is first-word fall-through: out_id and out_data show the head whenever out_valid=1.
- out_valid = (count != 0).
- Output values when out_valid=0:
  - out_id and out_data hold the last head value.
  - The checker treats them as don't-care.
- Full with simultaneous pop: a valid grant IS accepted; count stays DEPTH.
- Full without pop: the grant is dropped, overflow is set and held until rst, and count is unchanged.
- Empty with simultaneous push: no bypass. The push is stored and out_valid rises next cycle.
- Simultaneous push and pop when not full or empty: count is unchanged and both pointers advance.
- Pointer width is clog2(DEPTH); pointers wrap naturally at DEPTH.
- done is registered:
  - A pop at edge E drives done[popped id]=1 for exactly the cycle after E, and 0 otherwise.
  - Back-to-back pops give consecutive done pulses, possibly to different bits.
- Multi-hot grant: no push, onehot_err is set and sticky until rst, and the pop side operates normally.
- out_ready while out_valid=0: ignored.
- Handshake rule: the downstream resource may hold out_ready low indefinitely.
  - The head entry stays stable until it is popped.
- Ordering: entries are popped strictly in grant order.

Decomposition:
- Shared package grant_pkg, containing:
  - Constants N_REQ=4, DATA_W=8, ID_W=2.
  - An entry typedef {id, data}.
  - A one-hot-to-index function, reused by any future consumer of arbiter grants.
- One sub-module: sync_fifo (generic DEPTH x width storage, pointers and count, with full/empty).
- grant_dispatch_fifo wraps sync_fifo and adds grant classification, push gating, the sticky flags and done generation.

Test Plan:
- Single grant: with grant=4'b0100 and req_data slice 2=8'hA5 for one cycle, out_valid=1 the next cycle with out_id=2 and out_data=A5. With out_ready=1 the entry pops, done=4'b0100 for one cycle after, and count returns to 0.
- Burst with stall: grants 0001, 0010, 0100, 1000 in 4 consecutive cycles (data 11, 22, 33, 44) with out_ready=0 → count=4 and full=1. Releasing out_ready then gives pops in order with ids 0, 1, 2, 3, data 11, 22, 33, 44, and done pulses 0001, 0010, 0100, 1000 on consecutive cycles.
- Overflow: with the FIFO full and out_ready=0, grant=0010 → overflow=1 and count stays 4, and the dropped entry never appears. A later grant with full=1 and out_ready=1 is accepted, count stays 4 and overflow stays 1.
- Multi-hot: grant=0110 → onehot_err=1 and count unchanged; a subsequent grant=0001 pushes normally.
- Simultaneous push/pop: count=1, out_ready=1 and grant=1000 in the same cycle → count stays 1 and the next head is id 3.
- Reset mid-operation: count=3 and rst asserted for one cycle → next cycle count=0, out_valid=0, done=0, overflow=0 and onehot_err=0; no stale entries appear afterwards.
